// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - memory bus between the sequencer and a registered-read memory
interface cpu_sequencer_if;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [7:0]  mem_wdata;
    logic        mem_we;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/execute sequencer for a tiny 8-bit instruction set
module cpu_sequencer (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    cpu_sequencer_if.master        mem,
    output logic [7:0]             acc,
    output logic [15:0]            pc,
    output logic [3:0]             state,
    output logic                   halt
);
    typedef enum logic [3:0] {
        S_F0   = 4'd0,
        S_F1   = 4'd1,
        S_A0   = 4'd2,
        S_A1   = 4'd3,
        S_B0   = 4'd4,
        S_B1   = 4'd5,
        S_M0   = 4'd6,
        S_M1   = 4'd7,
        S_W0   = 4'd8,
        S_HALT = 4'd15
    } state_e;

    localparam logic [7:0] OP_NOP = 8'hEA;
    localparam logic [7:0] OP_LDI = 8'hA9;
    localparam logic [7:0] OP_LDA = 8'hAD;
    localparam logic [7:0] OP_STA = 8'h8D;
    localparam logic [7:0] OP_JMP = 8'h4C;

    state_e      state_q;
    logic [15:0] pc_q;
    logic [7:0]  acc_q;
    logic [7:0]  ir_q;
    logic [7:0]  lo_q;
    logic [7:0]  hi_q;
    logic        we_q;
    logic        halt_q;

    // Strobes are registered alongside the state so they drop with the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_F0;
            pc_q    <= 16'h0000;
            acc_q   <= 8'h00;
            ir_q    <= 8'h00;
            lo_q    <= 8'h00;
            hi_q    <= 8'h00;
            we_q    <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_F0: begin
                    if (run) state_q <= S_F1;
                end
                S_F1: begin
                    ir_q <= mem.mem_rdata;
                    pc_q <= pc_q + 16'd1;
                    case (mem.mem_rdata)
                        OP_NOP:                         state_q <= S_F0;
                        OP_LDI, OP_LDA, OP_STA, OP_JMP: state_q <= S_A0;
                        default: begin
                            state_q <= S_HALT;
                            halt_q  <= 1'b1;
                        end
                    endcase
                end
                S_A0: state_q <= S_A1;
                S_A1: begin
                    pc_q <= pc_q + 16'd1;
                    if (ir_q == OP_LDI) begin
                        acc_q   <= mem.mem_rdata;
                        state_q <= S_F0;
                    end else begin
                        lo_q    <= mem.mem_rdata;
                        state_q <= S_B0;
                    end
                end
                S_B0: state_q <= S_B1;
                S_B1: begin
                    hi_q <= mem.mem_rdata;
                    case (ir_q)
                        OP_JMP: begin
                            pc_q    <= {mem.mem_rdata, lo_q};
                            state_q <= S_F0;
                        end
                        OP_LDA: begin
                            pc_q    <= pc_q + 16'd1;
                            state_q <= S_M0;
                        end
                        OP_STA: begin
                            pc_q    <= pc_q + 16'd1;
                            state_q <= S_W0;
                            we_q    <= 1'b1;
                        end
                        default: begin
                            state_q <= S_HALT;
                            halt_q  <= 1'b1;
                        end
                    endcase
                end
                S_M0: state_q <= S_M1;
                S_M1: begin
                    acc_q   <= mem.mem_rdata;
                    state_q <= S_F0;
                end
                S_W0:   state_q <= S_F0;
                S_HALT: state_q <= S_HALT;
                default: begin
                    state_q <= S_HALT;
                    halt_q  <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        mem.mem_addr = pc_q;
        if (state_q == S_M0 || state_q == S_W0) mem.mem_addr = {hi_q, lo_q};
    end

    assign mem.mem_we    = we_q;
    assign mem.mem_wdata = acc_q;
    assign acc           = acc_q;
    assign pc            = pc_q;
    assign state         = state_q;
    assign halt          = halt_q;
endmodule
